// File: rtl/ascon_pack.sv
// Shared types and helpers for the ASCON output datapath.
// The byte mask is built MSB-first so byte 0 lands in the top byte of the rate.
package ascon_pack;

    localparam int CIPHER_BUF_DEPTH_DEFAULT = 4;
    localparam int STATE_WORDS              = 5;
    localparam int WORD_W                   = 64;
    localparam int MAX_RATE_WORDS           = 2;
    localparam int MAX_DATA_W               = WORD_W * MAX_RATE_WORDS;

    typedef logic [STATE_WORDS-1:0][WORD_W-1:0] type_state;

    // The mask sits in the low rate_words*64 bits; byte k is set when k < nbytes.
    function automatic logic [MAX_DATA_W-1:0] rate_byte_mask(
        input int unsigned nbytes,
        input int unsigned rate_words
    );
        logic [MAX_DATA_W-1:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < MAX_DATA_W / 8; k++) begin
            if (k < rate_words * 8) begin
                mask = {mask[MAX_DATA_W-9:0], (k < nbytes) ? 8'hFF : 8'h00};
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead FIFO with an explicit occupancy counter.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
    import ascon_pack::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = CIPHER_BUF_DEPTH_DEFAULT,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wrEn;
    logic             rdEn;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdEn    = pop_i & ~empty_o & ~clear_i;
    assign wrEn    = push_i & (~full_o | rdEn) & ~clear_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clear_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (rdEn) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({wrEn, rdEn})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrEn) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    // Stale storage is hidden once drained so consumers always see zero when empty.
    assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cipher_buffer.sv
// Ciphertext output stage: captures the ASCON rate, masks partial blocks and queues them.
// Outputs come only from FIFO storage, so state_i/enable_i never reach the host combinationally.
module cipher_buffer
    import ascon_pack::*;
#(
    parameter  int RATE_WORDS = 2,
    parameter  int DEPTH      = CIPHER_BUF_DEPTH_DEFAULT,
    localparam int DATA_W     = 64 * RATE_WORDS,
    localparam int NB_W       = $clog2(DATA_W / 8) + 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clock_i,
    input  logic              resetb_i,
    input  logic              clear_i,
    input  logic              enable_i,
    input  type_state         state_i,
    input  logic [NB_W-1:0]   nbytes_i,
    input  logic              last_i,
    output logic [DATA_W-1:0] cipher_o,
    output logic [NB_W-1:0]   cipher_nbytes_o,
    output logic              cipher_last_o,
    output logic              cipher_valid_o,
    input  logic              cipher_ready_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [NB_W-1:0]   nbytes;
        logic              last;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam logic [NB_W-1:0] MAX_BYTES = NB_W'(DATA_W / 8);

    logic [DATA_W-1:0]     rateWord;
    logic [NB_W-1:0]       nbClamped;
    logic [MAX_DATA_W-1:0] maskWide;
    entry_t                pushEntry;
    entry_t                headEntry;
    logic                  popReq;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  overflow_q, overflow_d;

    always_comb begin
        rateWord = '0;
        for (int w = 0; w < RATE_WORDS; w++) begin
            rateWord[64*w +: 64] = state_i[w];
        end
    end

    assign nbClamped = (nbytes_i > MAX_BYTES) ? MAX_BYTES : nbytes_i;
    assign maskWide  = rate_byte_mask({{(32-NB_W){1'b0}}, nbClamped}, RATE_WORDS);

    always_comb begin
        pushEntry        = '0;
        pushEntry.data   = rateWord & maskWide[DATA_W-1:0];
        pushEntry.nbytes = nbClamped;
        pushEntry.last   = last_i;
    end

    assign popReq = ~fifoEmpty & cipher_ready_i;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .clear_i  (clear_i),
        .push_i   (enable_i),
        .wdata_i  (pushEntry),
        .pop_i    (popReq),
        .rdata_o  (headEntry),
        .count_o  (count_o),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    // A drop happens only when full and no pop frees a slot in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (clear_i) begin
            overflow_d = 1'b0;
        end else if (enable_i && fifoFull && !popReq) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign cipher_o        = headEntry.data;
    assign cipher_nbytes_o = headEntry.nbytes;
    assign cipher_last_o   = headEntry.last;
    assign cipher_valid_o  = ~fifoEmpty;
    assign full_o          = fifoFull;
    assign empty_o         = fifoEmpty;
    assign overflow_o      = overflow_q;

endmodule

// File: doc/cipher_buffer.md
Name: cipher_buffer

Overview:
- Parametrised output stage for ciphertext blocks. On each enable pulse it captures the rate words of the ASCON state, zero-masks any partial final block, and pushes the block into a small FIFO.
- The FIFO drains over a valid/ready stream to the host interface, so the permutation core never stalls on a slow consumer.
- Supports a 64-bit rate (RATE_WORDS=1) and a 128-bit rate (RATE_WORDS=2), with configurable depth.

Parameters:
- RATE_WORDS, 2, number of 64-bit state words captured per block (1 or 2); DATA_W = 64*RATE_WORDS.
- DEPTH, 4, FIFO entries (power of two, 2..16).
- NB_W, derived = $clog2(DATA_W/8)+1, width of byte-count fields.

Ports:
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush of FIFO and overflow flag
- enable_i  in  1  capture/push strobe, one block per cycle high
- state_i  in  type_state  ASCON state; words [RATE_WORDS-1:0] used
- nbytes_i  in  NB_W  valid bytes in captured block (0..DATA_W/8)
- last_i  in  1  captured block is final block of message
- cipher_o  out  DATA_W  head-of-FIFO block
- cipher_nbytes_o  out  NB_W  byte count of head block
- cipher_last_o  out  1  last flag of head block
- cipher_valid_o  out  1  head entry valid (= !empty)
- cipher_ready_i  in  1  consumer accepts head this cycle
- count_o  out  $clog2(DEPTH+1)  entries held
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- overflow_o  out  1  sticky: a push was dropped

Behaviour:
- Reset (resetb_i=0, async): all entries, pointers and count cleared. cipher_o=0, cipher_nbytes_o=0, cipher_last_o=0, cipher_valid_o=0, count_o=0, full_o=0, empty_o=1, overflow_o=0.
- Capture word: {state_i[RATE_WORDS-1], ..., state_i[0]}; for RATE_WORDS=2 this is {state_i[1], state_i[0]}.
- Byte k (k=0 is MSB) occupies bits [DATA_W-1-8k -: 8].
- Masking: bytes with k >= nbytes_i are forced to 0. nbytes_i > DATA_W/8 clamps to DATA_W/8, and the clamped value is stored. nbytes_i=0 stores an all-zero block with count 0 (empty final block).
- Push = enable_i. Pop = cipher_valid_o & cipher_ready_i.
- Show-ahead FIFO: a push into an empty FIFO is visible on cipher_o, with cipher_valid_o=1, the next cycle (1-cycle latency).
- Outputs are driven from registered storage through head-pointer muxing only; no combinational path from state_i or enable_i.
- Push and pop in the same cycle, FIFO not empty and not full: both happen, count unchanged.
- Push and pop in the same cycle, FIFO full: both happen, push accepted, count stays DEPTH, overflow not set.
- Push when full without pop: block dropped, FIFO contents unchanged, overflow_o=1 from the next cycle.
- overflow_o holds until clear_i or reset.
- Pop when empty cannot occur, because valid=0.
- Pointers wrap modulo DEPTH. Count is tracked separately, so full and empty are unambiguous.
- clear_i=1 overrides push/pop that cycle. Next cycle: count=0, empty=1, overflow=0, cipher_o/nbytes/last = 0. Storage contents need not be zeroed, but the outputs read 0 when empty.
- Head fields (data, nbytes, last) stay stable while cipher_valid_o=1 and cipher_ready_i=0.
- Reset mid-stream discards all pending blocks immediately.

Decomposition:
- ascon_pack gets:
  - constant CIPHER_BUF_DEPTH_DEFAULT=4
  - function rate_byte_mask(nbytes, rate_words), returning the DATA_W-bit mask
  - typedef for a FIFO entry struct (data, nbytes, last); the struct is parameter-dependent, so it is declared locally in cipher_buffer.
- One sub-module: sync_fifo (generic width/depth, show-ahead, count, full/empty). cipher_buffer holds the capture/mask/clamp logic and the overflow flag, and instantiates sync_fifo with width DATA_W+NB_W+1.

Test Plan:
- Reset check: hold resetb_i=0 with enable_i=1 -> all outputs at reset values, empty_o=1, no entry captured. Release -> still empty.
- Single full block, RATE_WORDS=2: state_i[1]=64'h0123456789ABCDEF, state_i[0]=64'hFEDCBA9876543210, nbytes_i=16, last_i=1, one-cycle enable -> next cycle cipher_o=128'h0123456789ABCDEFFEDCBA9876543210, nbytes=16, last=1, valid=1. Ready=1 -> empty next cycle.
- Partial block: same state, nbytes_i=5 -> cipher_o=128'h0123456789000000_0000000000000000, nbytes=5. nbytes_i=20 -> full block stored, nbytes=16.
- Fill and overflow, DEPTH=4, ready=0: push blocks 1..5 -> count 4, full=1, block 5 dropped, overflow=1. Drain -> order 1,2,3,4. clear_i -> overflow=0.
- Full with simultaneous push+pop: FIFO full, ready=1 and enable=1 -> block 1 popped, new block accepted, count stays 4, overflow stays 0.
- Backpressure and RATE_WORDS=1: ready toggling 1010 over 8 pushes -> all 8 blocks delivered in order, head stable while stalled. With RATE_WORDS=1, state_i[0]=64'hAABBCCDDEEFF0011 and nbytes_i=3 -> cipher_o=64'hAABBCC0000000000.
